// File: rtl/vga_linefetch.sv
// vga_linefetch
// Scanline prefetcher sitting between the SDRAM controller and vgaout.
// While vgaout displays line V from one half of a ping-pong line buffer,
// line V+1 is fetched from SDRAM into the other half, one word per pixel.
//
// Ports
//   clk, rst_n          sole clock, asynchronous active-low reset
//   vram_h, vram_v      pixel lookup from vgaout (vram_v also drives line events)
//   vram_data           24-bit RGB, valid two clocks after the lookup
//   mem_req, mem_addr   read request / word address to the SDRAM controller
//   mem_data, mem_ack   read data, valid in the single-cycle ack pulse
//   busy                high while a line fetch (or drain) is in progress
//   underrun            sticky: a line event arrived before the fetch finished
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no request outstanding, waiting for a line event with a target
// S_REQ   | requesting word i of the target line, mem_addr held until ack
// S_DRAIN | line aborted; wait for the outstanding ack, discard its data

module vga_linefetch #(
    parameter int          H_ACTIVE    = 640,
    parameter int          V_ACTIVE    = 480,
    parameter logic [21:0] BASE_ADDR   = 22'h0,
    parameter int          LINE_STRIDE = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  vram_h,
    input  logic [9:0]  vram_v,
    output logic [23:0] vram_data,
    output logic        mem_req,
    output logic [21:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic        mem_ack,
    output logic        busy,
    output logic        underrun
);

    localparam int          BUF_WORDS = 2 * H_ACTIVE;
    localparam int          BUF_AW    = $clog2(BUF_WORDS);
    localparam int          IW        = $clog2(H_ACTIVE);
    localparam logic [IW-1:0]     I_LAST    = IW'(H_ACTIVE - 1);
    localparam logic [10:0]       H_LIM     = 11'(H_ACTIVE);
    localparam logic [10:0]       V_LIM     = 11'(V_ACTIVE);
    localparam logic [10:0]       V_LAST    = 11'(V_ACTIVE - 1);
    localparam logic [21:0]       STRIDE22  = 22'(LINE_STRIDE);
    localparam logic [BUF_AW-1:0] HALF1_OFS = BUF_AW'(H_ACTIVE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     i_q, i_d;
    logic [21:0]       addr_q, addr_d;
    logic              half_q, half_d;
    logic              pend_valid_q, pend_valid_d;
    logic [21:0]       pend_base_q, pend_base_d;
    logic              pend_half_q, pend_half_d;
    logic              underrun_q, underrun_d;
    logic [9:0]        prev_v_q, prev_v_d;
    logic              line0_q, line0_d;
    logic              rd_ok_q, rd_ok_d;
    logic [BUF_AW-1:0] rd_idx_q, rd_idx_d;
    logic [23:0]       vram_data_q, vram_data_d;

    logic [23:0]       buf_mem [BUF_WORDS];
    logic              buf_we;
    logic [BUF_AW-1:0] wr_idx;

    logic              line_ev;
    logic              tgt_valid;
    logic [9:0]        tgt_line;
    logic [21:0]       tgt_base;

    logic              unused_hi;
    assign unused_hi = ^mem_data[31:24];

    // Line event decode and target selection. line0_q remembers that line 0
    // has been scheduled for this frame so the blanking lines do not refetch it.
    always_comb begin
        line_ev   = (vram_v != prev_v_q);
        tgt_valid = 1'b0;
        tgt_line  = '0;
        if (line_ev) begin
            if ({1'b0, vram_v} < V_LAST) begin
                tgt_valid = 1'b1;
                tgt_line  = vram_v + 10'd1;
            end else if ({1'b0, vram_v} == V_LAST) begin
                tgt_valid = 1'b1;
            end else if (!line0_q) begin
                tgt_valid = 1'b1;
            end
        end
    end

    assign tgt_base = BASE_ADDR + ({12'b0, tgt_line} * STRIDE22);

    always_comb begin
        prev_v_d = vram_v;
        line0_d  = line0_q;
        if (line_ev && ({1'b0, vram_v} < V_LAST)) begin
            line0_d = 1'b0;
        end
        if (tgt_valid && (tgt_line == 10'd0)) begin
            line0_d = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        addr_d       = addr_q;
        half_d       = half_q;
        pend_valid_d = pend_valid_q;
        pend_base_d  = pend_base_q;
        pend_half_d  = pend_half_q;
        underrun_d   = underrun_q;
        buf_we       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tgt_valid) begin
                    state_d = S_REQ;
                    i_d     = '0;
                    addr_d  = tgt_base;
                    half_d  = tgt_line[0];
                end
            end

            S_REQ: begin
                if (mem_ack) begin
                    buf_we = 1'b1;
                    if (i_q == I_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        i_d    = i_q + IW'(1);
                        addr_d = addr_q + 22'd1;
                    end
                end
                if (line_ev) begin
                    // An ack in the same cycle is consumed first; only a line
                    // left unfinished counts as an underrun.
                    if (!(mem_ack && (i_q == I_LAST))) begin
                        underrun_d = 1'b1;
                    end
                    if (mem_ack) begin
                        if (tgt_valid) begin
                            state_d = S_REQ;
                            i_d     = '0;
                            addr_d  = tgt_base;
                            half_d  = tgt_line[0];
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        // Request still outstanding: keep mem_addr stable and
                        // park the new target until the ack arrives.
                        state_d      = S_DRAIN;
                        pend_valid_d = tgt_valid;
                        pend_base_d  = tgt_base;
                        pend_half_d  = tgt_line[0];
                    end
                end
            end

            S_DRAIN: begin
                if (line_ev) begin
                    pend_valid_d = tgt_valid;
                    pend_base_d  = tgt_base;
                    pend_half_d  = tgt_line[0];
                end
                if (mem_ack) begin
                    if (line_ev ? tgt_valid : pend_valid_q) begin
                        state_d = S_REQ;
                        i_d     = '0;
                        addr_d  = line_ev ? tgt_base : pend_base_q;
                        half_d  = line_ev ? tgt_line[0] : pend_half_q;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign wr_idx = BUF_AW'(i_q) + (half_q ? HALF1_OFS : '0);

    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_mem[wr_idx] <= mem_data[23:0];
        end
    end

    // Read pipeline: lookup registered in stage 1, buffer word in stage 2.
    always_comb begin
        rd_ok_d  = ({1'b0, vram_h} < H_LIM) && ({1'b0, vram_v} < V_LIM);
        rd_idx_d = '0;
        if (rd_ok_d) begin
            rd_idx_d = BUF_AW'(vram_h) + (vram_v[0] ? HALF1_OFS : '0);
        end
        vram_data_d = rd_ok_q ? buf_mem[rd_idx_q] : 24'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            i_q          <= '0;
            addr_q       <= '0;
            half_q       <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_base_q  <= '0;
            pend_half_q  <= 1'b0;
            underrun_q   <= 1'b0;
            prev_v_q     <= 10'h3FF;
            line0_q      <= 1'b0;
            rd_ok_q      <= 1'b0;
            rd_idx_q     <= '0;
            vram_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            addr_q       <= addr_d;
            half_q       <= half_d;
            pend_valid_q <= pend_valid_d;
            pend_base_q  <= pend_base_d;
            pend_half_q  <= pend_half_d;
            underrun_q   <= underrun_d;
            prev_v_q     <= prev_v_d;
            line0_q      <= line0_d;
            rd_ok_q      <= rd_ok_d;
            rd_idx_q     <= rd_idx_d;
            vram_data_q  <= vram_data_d;
        end
    end

    assign mem_req   = (state_q != S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign mem_addr  = addr_q;
    assign underrun  = underrun_q;
    assign vram_data = vram_data_q;

endmodule

// File: tb/tb_vga_linefetch.sv
// Testbench for vga_linefetch: random SDRAM data and ack gaps, random pixel
// reads checked against a line-buffer model, plus frame-end, underrun,
// same-cycle completion, out-of-range and address-wrap scenarios.

module tb_vga_linefetch;

    localparam int          H      = 640;
    localparam int          V      = 480;
    localparam int          STRIDE = 1024;
    localparam logic [21:0] BASE   = 22'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  vram_h = '0;
    logic [9:0]  vram_v = '0;
    logic [23:0] vram_data;
    logic        mem_req;
    logic [21:0] mem_addr;
    logic [31:0] mem_data = '0;
    logic        mem_ack = 1'b0;
    logic        busy;
    logic        underrun;

    logic [9:0]  w_h = '0;
    logic [9:0]  w_v = '0;
    logic [23:0] w_data;
    logic        w_req;
    logic [21:0] w_addr;
    logic [31:0] w_mdata = '0;
    logic        w_ack = 1'b0;
    logic        w_busy;
    logic        w_under;

    vga_linefetch u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vram_h    (vram_h),
        .vram_v    (vram_v),
        .vram_data (vram_data),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ack   (mem_ack),
        .busy      (busy),
        .underrun  (underrun)
    );

    vga_linefetch #(
        .H_ACTIVE    (16),
        .V_ACTIVE    (8),
        .BASE_ADDR   (22'h3FFF00),
        .LINE_STRIDE (1024)
    ) u_wrap (
        .clk       (clk),
        .rst_n     (rst_n),
        .vram_h    (w_h),
        .vram_v    (w_v),
        .vram_data (w_data),
        .mem_req   (w_req),
        .mem_addr  (w_addr),
        .mem_data  (w_mdata),
        .mem_ack   (w_ack),
        .busy      (w_busy),
        .underrun  (w_under)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: contents of each buffer half, the line being fetched
    // and how many of its words have been accepted.
    logic [23:0] model_buf [2][H];
    int          exp_line;
    int          exp_i;
    bit          exp_has;
    bit          m_line0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [21:0] exp_addr(input int line, input int i);
        return 22'(32'(BASE) + line * STRIDE + i);
    endfunction

    task automatic model_event(input logic [9:0] v);
        exp_has = 1'b1;
        if (int'(v) < V - 1) begin
            exp_line = int'(v) + 1;
            m_line0  = 1'b0;
        end else if (int'(v) == V - 1) begin
            exp_line = 0;
            m_line0  = 1'b1;
        end else if (!m_line0) begin
            exp_line = 0;
            m_line0  = 1'b1;
        end else begin
            exp_has = 1'b0;
        end
        if (exp_has) exp_i = 0;
    endtask

    task automatic set_v(input logic [9:0] v);
        @(negedge clk);
        vram_v = v;
        model_event(v);
    endtask

    task automatic ack_word(input logic [31:0] d);
        int n = 0;
        while (!mem_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!mem_req) check("req_timeout", 32'(mem_req), 32'd1);
        repeat ($urandom_range(0, 1)) @(negedge clk);
        check("fetch_addr", 32'(mem_addr), 32'(exp_addr(exp_line, exp_i)));
        mem_data = d;
        mem_ack  = 1'b1;
        model_buf[exp_line % 2][exp_i] = d[23:0];
        exp_i++;
        @(negedge clk);
        mem_ack = 1'b0;
    endtask

    task automatic fetch_rest();
        while (exp_i < H) ack_word($urandom);
        check("busy_done", 32'(busy), 32'd0);
    endtask

    task automatic read_px(input logic [9:0] h, output logic [23:0] d);
        @(negedge clk);
        vram_h = h;
        @(negedge clk);
        @(negedge clk);
        d = vram_data;
    endtask

    task automatic check_px(input logic [9:0] h);
        logic [23:0] d;
        logic [23:0] e;
        read_px(h, d);
        if (int'(h) >= H || int'(vram_v) >= V) e = 24'h0;
        else e = model_buf[vram_v[0]][h];
        check("pixel", 32'(d), 32'(e));
    endtask

    task automatic expect_idle(input string tag);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check(tag, 32'(mem_req), 32'd0);
        end
    endtask

    initial begin
        logic [23:0] d;
        logic [21:0] old_addr;
        logic [31:0] w;
        m_line0 = 1'b0;
        exp_i   = 0;
        exp_line = 0;

        repeat (3) @(negedge clk);
        check("rst_vram_data", 32'(vram_data), 32'd0);
        check("rst_mem_req",   32'(mem_req),   32'd0);
        check("rst_mem_addr",  32'(mem_addr),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_underrun",  32'(underrun),  32'd0);
        check("rst_wrap_data", 32'(w_data),    32'd0);

        rst_n = 1'b1;
        model_event(10'd0);
        @(negedge clk);
        check("req_rise",   32'(mem_req),  32'd1);
        check("first_addr", 32'(mem_addr), 32'(exp_addr(1, 0)));
        check("busy_rise",  32'(busy),     32'd1);

        // Address wrap instance: 0x3FFF00 + 1024 + i truncated to 22 bits.
        for (int i = 0; i < 16; i++) begin
            check("wrap_addr", 32'(w_addr), 32'(22'(32'h3FFF00 + 1024 + i)));
            w_mdata = $urandom;
            w_ack   = 1'b1;
            @(negedge clk);
        end
        w_ack = 1'b0;
        check("wrap_busy",     32'(w_busy),  32'd0);
        check("wrap_underrun", 32'(w_under), 32'd0);

        // Line 1 with recognisable data.
        while (exp_i < H) ack_word(32'hAA000000 + 32'(exp_i));
        check("busy_fall",  32'(busy),     32'd0);
        check("req_fall",   32'(mem_req),  32'd0);
        check("no_underrun", 32'(underrun), 32'd0);
        set_v(10'd1);
        read_px(10'd5, d);
        check("px_h5", 32'(d), 32'h000005);
        for (int k = 0; k < 6; k++) check_px(10'($urandom_range(0, H + 100)));

        for (int ln = 2; ln <= 4; ln++) begin
            fetch_rest();
            check("no_underrun", 32'(underrun), 32'd0);
            set_v(10'(ln));
            for (int k = 0; k < 6; k++) check_px(10'($urandom_range(0, H + 100)));
        end

        // Line event together with the last ack of line 5.
        while (exp_i < H - 1) ack_word($urandom);
        check("last_addr", 32'(mem_addr), 32'(exp_addr(exp_line, H - 1)));
        w = $urandom;
        mem_data = w;
        mem_ack  = 1'b1;
        model_buf[exp_line % 2][H - 1] = w[23:0];
        vram_v = 10'd5;
        model_event(10'd5);
        @(negedge clk);
        mem_ack = 1'b0;
        check("same_cyc_underrun", 32'(underrun), 32'd0);
        check("same_cyc_req",      32'(mem_req),  32'd1);
        check("same_cyc_addr",     32'(mem_addr), 32'(exp_addr(exp_line, 0)));
        fetch_rest();
        check_px(10'(H - 1));
        for (int k = 0; k < 4; k++) check_px(10'($urandom_range(0, H - 1)));

        // Frame end.
        set_v(10'd477);
        fetch_rest();
        set_v(10'd478);
        fetch_rest();
        set_v(10'd479);
        @(negedge clk);
        check("line0_addr", 32'(mem_addr), 32'(BASE));
        fetch_rest();
        set_v(10'd480);
        expect_idle("no_fetch_480");
        check_px(10'd10);
        set_v(10'd481);
        expect_idle("no_fetch_481");
        set_v(10'd500);
        expect_idle("no_fetch_500");
        check_px(10'd10);
        check("no_underrun", 32'(underrun), 32'd0);
        set_v(10'd0);
        check_px(10'd700);
        for (int k = 0; k < 6; k++) check_px(10'($urandom_range(0, H - 1)));

        // Underrun: line event after 100 acks of line 1.
        while (exp_i < 100) ack_word($urandom);
        old_addr = exp_addr(exp_line, 100);
        set_v(10'd1);
        @(negedge clk);
        check("underrun_set",  32'(underrun), 32'd1);
        check("drain_req",     32'(mem_req),  32'd1);
        check("drain_addr",    32'(mem_addr), 32'(old_addr));
        @(negedge clk);
        check("drain_req_hold", 32'(mem_req), 32'd1);
        mem_data = 32'h00BEEF00;
        mem_ack  = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("after_drain_req",  32'(mem_req),  32'd1);
        check("after_drain_addr", 32'(mem_addr), 32'(exp_addr(exp_line, 0)));
        check_px(10'd100);
        check_px(10'd50);
        check("underrun_sticky", 32'(underrun), 32'd1);

        // Reset in the middle of a fetch.
        for (int k = 0; k < 10; k++) ack_word($urandom);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_req",      32'(mem_req),   32'd0);
        check("midrst_busy",     32'(busy),      32'd0);
        check("midrst_underrun", 32'(underrun),  32'd0);
        check("midrst_addr",     32'(mem_addr),  32'd0);
        check("midrst_data",     32'(vram_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
